vliw_id_ex_pipe: RTL and testbench

Parametrised ID/EX pipeline register for the VLIW core, generalised from a fixed two-slot ALU+MEM bundle to NUM_SLOTS issue slots of configurable width. Sits between register read/decode and execute. Adds per-slot valid bits, downstream stall hold, branch/jump flush, and a load-use interlock that inserts a one-cycle bubble and freezes IF/ID.

---
 rtl/vliw_id_ex_pipe.sv | 141 ++++++++++++++
 tb/tb_vliw_id_ex_pipe.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/vliw_id_ex_pipe.sv
// ID/EX pipeline register for an N-slot VLIW bundle with stall hold, flush, and a one-cycle load-use bubble.
// Optional writeback-to-ID bypass on capture is enabled by defining VLIW_WB_BYPASS_EN.
module vliw_id_ex_pipe #(
  parameter int NUM_SLOTS = 2,
  parameter int DATA_W    = 32,
  parameter int RADDR_W   = 3,
  parameter int CTRL_W    = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_SLOTS-1:0]           id_valid,
  input  logic [NUM_SLOTS*RADDR_W-1:0]   id_rs1,
  input  logic [NUM_SLOTS*RADDR_W-1:0]   id_rs2,
  input  logic [NUM_SLOTS*RADDR_W-1:0]   id_rd,
  input  logic [NUM_SLOTS-1:0]           id_use_rs1,
  input  logic [NUM_SLOTS-1:0]           id_use_rs2,
  input  logic [NUM_SLOTS*DATA_W-1:0]    id_rs1_data,
  input  logic [NUM_SLOTS*DATA_W-1:0]    id_rs2_data,
  input  logic [NUM_SLOTS*DATA_W-1:0]    id_imm,
  input  logic [NUM_SLOTS*CTRL_W-1:0]    id_ctrl,
  input  logic [NUM_SLOTS-1:0]           id_reg_write,
  input  logic [NUM_SLOTS-1:0]           id_is_load,
  input  logic                           ex_stall,
  input  logic                           flush,
  input  logic [NUM_SLOTS-1:0]           wb_we,
  input  logic [NUM_SLOTS*RADDR_W-1:0]   wb_addr,
  input  logic [NUM_SLOTS*DATA_W-1:0]    wb_data,
  output logic [NUM_SLOTS-1:0]           ex_valid,
  output logic [NUM_SLOTS-1:0]           ex_reg_write,
  output logic [NUM_SLOTS-1:0]           ex_is_load,
  output logic [NUM_SLOTS*RADDR_W-1:0]   ex_rs1,
  output logic [NUM_SLOTS*RADDR_W-1:0]   ex_rs2,
  output logic [NUM_SLOTS*RADDR_W-1:0]   ex_rd,
  output logic [NUM_SLOTS*DATA_W-1:0]    ex_rs1_data,
  output logic [NUM_SLOTS*DATA_W-1:0]    ex_rs2_data,
  output logic [NUM_SLOTS*DATA_W-1:0]    ex_imm,
  output logic [NUM_SLOTS*CTRL_W-1:0]    ex_ctrl,
  output logic                           hold_id
);

  logic [NUM_SLOTS-1:0]         r_ex_valid, r_ex_reg_write, r_ex_is_load;
  logic [NUM_SLOTS*RADDR_W-1:0] r_ex_rs1, r_ex_rs2, r_ex_rd;
  logic [NUM_SLOTS*DATA_W-1:0]  r_ex_rs1_data, r_ex_rs2_data, r_ex_imm;
  logic [NUM_SLOTS*CTRL_W-1:0]  r_ex_ctrl;

  logic                         w_load_use;
  logic                         w_capture;
  logic                         w_clear;
  logic [NUM_SLOTS*DATA_W-1:0]  w_rs1_sel, w_rs2_sel;
  logic [NUM_SLOTS*CTRL_W-1:0]  w_ctrl_gated;

  // Every EX load is compared against every ID source, same slot included.
  always_comb begin
    w_load_use = 1'b0;
    for (int j = 0; j < NUM_SLOTS; j++) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (r_ex_valid[j] && r_ex_is_load[j] && r_ex_reg_write[j] && id_valid[i] &&
            ((id_use_rs1[i] && (id_rs1[i*RADDR_W +: RADDR_W] == r_ex_rd[j*RADDR_W +: RADDR_W])) ||
             (id_use_rs2[i] && (id_rs2[i*RADDR_W +: RADDR_W] == r_ex_rd[j*RADDR_W +: RADDR_W]))))
          w_load_use = 1'b1;
      end
    end
  end

  assign hold_id   = ~flush & (ex_stall | w_load_use);
  assign w_capture = ~flush & ~ex_stall & ~w_load_use;
  assign w_clear   = flush | (~ex_stall & w_load_use);

  always_comb begin
    w_rs1_sel = id_rs1_data;
    w_rs2_sel = id_rs2_data;
`ifdef VLIW_WB_BYPASS_EN
    // Ascending k so the highest matching writeback port wins.
    for (int i = 0; i < NUM_SLOTS; i++) begin
      for (int k = 0; k < NUM_SLOTS; k++) begin
        if (wb_we[k] && (wb_addr[k*RADDR_W +: RADDR_W] == id_rs1[i*RADDR_W +: RADDR_W]))
          w_rs1_sel[i*DATA_W +: DATA_W] = wb_data[k*DATA_W +: DATA_W];
        if (wb_we[k] && (wb_addr[k*RADDR_W +: RADDR_W] == id_rs2[i*RADDR_W +: RADDR_W]))
          w_rs2_sel[i*DATA_W +: DATA_W] = wb_data[k*DATA_W +: DATA_W];
      end
    end
`endif
  end

`ifndef VLIW_WB_BYPASS_EN
  logic w_unused_wb;
  assign w_unused_wb = ^{wb_we, wb_addr, wb_data};
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
      assign w_ctrl_gated[gi*CTRL_W +: CTRL_W] =
        id_valid[gi] ? id_ctrl[gi*CTRL_W +: CTRL_W] : {CTRL_W{1'b0}};
    end
  endgenerate

  // Flush and bubble only kill the qualifying bits; data/address registers hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ex_valid     <= '0;
      r_ex_reg_write <= '0;
      r_ex_is_load   <= '0;
      r_ex_rs1       <= '0;
      r_ex_rs2       <= '0;
      r_ex_rd        <= '0;
      r_ex_rs1_data  <= '0;
      r_ex_rs2_data  <= '0;
      r_ex_imm       <= '0;
      r_ex_ctrl      <= '0;
    end else if (w_clear) begin
      r_ex_valid     <= '0;
      r_ex_reg_write <= '0;
      r_ex_is_load   <= '0;
      r_ex_ctrl      <= '0;
    end else if (w_capture) begin
      r_ex_valid     <= id_valid;
      r_ex_reg_write <= id_valid & id_reg_write;
      r_ex_is_load   <= id_valid & id_is_load;
      r_ex_rs1       <= id_rs1;
      r_ex_rs2       <= id_rs2;
      r_ex_rd        <= id_rd;
      r_ex_rs1_data  <= w_rs1_sel;
      r_ex_rs2_data  <= w_rs2_sel;
      r_ex_imm       <= id_imm;
      r_ex_ctrl      <= w_ctrl_gated;
    end
  end

  assign ex_valid     = r_ex_valid;
  assign ex_reg_write = r_ex_reg_write;
  assign ex_is_load   = r_ex_is_load;
  assign ex_rs1       = r_ex_rs1;
  assign ex_rs2       = r_ex_rs2;
  assign ex_rd        = r_ex_rd;
  assign ex_rs1_data  = r_ex_rs1_data;
  assign ex_rs2_data  = r_ex_rs2_data;
  assign ex_imm       = r_ex_imm;
  assign ex_ctrl      = r_ex_ctrl;

endmodule

// File: tb/tb_vliw_id_ex_pipe.sv
// Scoreboard bench for vliw_id_ex_pipe: the driver queues hand-computed expectations,
// a negedge monitor pops and compares them against the EX registers and hold_id.
module tb_vliw_id_ex_pipe;
  localparam int NS = 2, DW = 32, AW = 3, CW = 8;

  logic clk = 1'b0;
  logic reset;
  logic [NS-1:0]    id_valid, id_use_rs1, id_use_rs2, id_reg_write, id_is_load, wb_we;
  logic [NS*AW-1:0] id_rs1, id_rs2, id_rd, wb_addr;
  logic [NS*DW-1:0] id_rs1_data, id_rs2_data, id_imm, wb_data;
  logic [NS*CW-1:0] id_ctrl;
  logic             ex_stall, flush;
  logic [NS-1:0]    ex_valid, ex_reg_write, ex_is_load;
  logic [NS*AW-1:0] ex_rs1, ex_rs2, ex_rd;
  logic [NS*DW-1:0] ex_rs1_data, ex_rs2_data, ex_imm;
  logic [NS*CW-1:0] ex_ctrl;
  logic             hold_id;

  always #5 clk = ~clk;

  vliw_id_ex_pipe #(.NUM_SLOTS(NS), .DATA_W(DW), .RADDR_W(AW), .CTRL_W(CW)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_ctrl(id_ctrl), .id_reg_write(id_reg_write), .id_is_load(id_is_load),
    .ex_stall(ex_stall), .flush(flush),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_ctrl(ex_ctrl), .hold_id(hold_id)
  );

  typedef struct {
    string        tag;
    logic [1:0]   valid, regw, load;
    logic [5:0]   rd;
    logic [63:0]  rs1d, imm;
    logic [15:0]  ctrl;
    logic         hold;
    bit           chk_data;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic push(input string tag, input logic [1:0] v, input logic [1:0] rw, input logic [1:0] ld,
                      input logic [5:0] rd, input logic [63:0] rs1d, input logic [63:0] imm,
                      input logic [15:0] ctrl, input logic hold, input bit chk_data);
    exp_t e;
    e.tag = tag; e.valid = v; e.regw = rw; e.load = ld; e.rd = rd; e.rs1d = rs1d;
    e.imm = imm; e.ctrl = ctrl; e.hold = hold; e.chk_data = chk_data;
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check({e.tag, ".valid"}, 64'(ex_valid), 64'(e.valid));
        check({e.tag, ".regw"},  64'(ex_reg_write), 64'(e.regw));
        check({e.tag, ".load"},  64'(ex_is_load), 64'(e.load));
        check({e.tag, ".ctrl"},  64'(ex_ctrl), 64'(e.ctrl));
        check({e.tag, ".hold"},  64'(hold_id), 64'(e.hold));
        if (e.chk_data) begin
          check({e.tag, ".rd"},   64'(ex_rd), 64'(e.rd));
          check({e.tag, ".rs1d"}, ex_rs1_data, e.rs1d);
          check({e.tag, ".imm"},  ex_imm, e.imm);
        end
        $display("txn %-10s ex_valid=%b hold_id=%b rs1d=%h imm=%h ctrl=%h",
                 e.tag, ex_valid, hold_id, ex_rs1_data, ex_imm, ex_ctrl);
      end
    end
  end

  task automatic clear_id();
    id_valid = '0; id_use_rs1 = '0; id_use_rs2 = '0; id_reg_write = '0; id_is_load = '0;
    id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_rs1_data = '0; id_rs2_data = '0;
    id_imm = '0; id_ctrl = '0; wb_we = '0; wb_addr = '0; wb_data = '0;
  endtask

  task automatic set_slot(input int s, input logic v, input logic [2:0] rs1, input logic u1,
                          input logic [2:0] rs2, input logic u2, input logic [2:0] rd,
                          input logic [31:0] d1, input logic [31:0] imm, input logic [7:0] ctrl,
                          input logic rw, input logic ld);
    id_valid[s] = v; id_use_rs1[s] = u1; id_use_rs2[s] = u2;
    id_reg_write[s] = rw; id_is_load[s] = ld;
    id_rs1[s*AW +: AW] = rs1; id_rs2[s*AW +: AW] = rs2; id_rd[s*AW +: AW] = rd;
    id_rs1_data[s*DW +: DW] = d1; id_rs2_data[s*DW +: DW] = 32'h0;
    id_imm[s*DW +: DW] = imm; id_ctrl[s*CW +: CW] = ctrl;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] byp;

  initial begin : driver
`ifdef VLIW_WB_BYPASS_EN
    byp = 32'hBB;
`else
    byp = 32'h00;
`endif
    reset = 1'b0; ex_stall = 1'b0; flush = 1'b0;
    clear_id();
    // C0: in reset with a live bundle presented
    cyc();
    set_slot(0, 1, 3'd3, 1, 3'd0, 0, 3'd4, 32'h11, 32'hFFFFFFFE, 8'h5A, 1, 0);
    push("reset", 2'b00, 2'b00, 2'b00, 6'h00, 64'h0, 64'h0, 16'h0, 0, 1);
    // C1: release reset
    cyc(); reset = 1'b1;
    push("rel", 2'b00, 2'b00, 2'b00, 6'h00, 64'h0, 64'h0, 16'h0, 0, 1);
    // C2: first capture; present slot1 load rd=5 plus an invalid slot0 with junk control
    cyc();
    clear_id();
    set_slot(0, 0, 3'd0, 0, 3'd0, 0, 3'd7, 32'h22, 32'h33, 8'hFF, 1, 1);
    set_slot(1, 1, 3'd1, 0, 3'd0, 0, 3'd5, 32'h44, 32'h55, 8'h81, 1, 1);
    push("capture", 2'b01, 2'b01, 2'b00, 6'h04, {32'h0, 32'h11}, {32'h0, 32'hFFFFFFFE}, 16'h005A, 0, 1);
    // C3: slot0 reads rs2=5 against the EX load -> hazard
    cyc();
    clear_id();
    set_slot(0, 1, 3'd0, 0, 3'd5, 1, 3'd1, 32'h66, 32'h77, 8'h12, 1, 0);
    push("ldex", 2'b10, 2'b10, 2'b10, 6'h2F, {32'h44, 32'h22}, {32'h55, 32'h33}, 16'h8100, 1, 1);
    // C4: bubble, ID held
    cyc();
    push("bubble", 2'b00, 2'b00, 2'b00, 6'h00, 64'h0, 64'h0, 16'h0, 0, 0);
    // C5: held bundle captured; reload EX with load rd=5
    cyc();
    clear_id();
    set_slot(1, 1, 3'd1, 0, 3'd0, 0, 3'd5, 32'h44, 32'h55, 8'h81, 1, 1);
    push("afterbub", 2'b01, 2'b01, 2'b00, 6'h01, {32'h0, 32'h66}, {32'h0, 32'h77}, 16'h0012, 0, 1);
    // C6: rs2=5 present but not used -> no hazard
    cyc();
    clear_id();
    set_slot(0, 1, 3'd5, 0, 3'd5, 0, 3'd2, 32'h99, 32'hAA, 8'h34, 1, 0);
    push("nohaz", 2'b10, 2'b10, 2'b10, 6'h28, {32'h44, 32'h0}, {32'h55, 32'h0}, 16'h8100, 0, 1);
    // C7..C9: stall with a new bundle pending
    cyc();
    clear_id();
    ex_stall = 1'b1;
    set_slot(0, 1, 3'd0, 0, 3'd0, 0, 3'd3, 32'hB1, 32'hB2, 8'h56, 1, 0);
    set_slot(1, 1, 3'd0, 0, 3'd0, 0, 3'd6, 32'hC1, 32'hC2, 8'h78, 1, 1);
    push("stall0", 2'b01, 2'b01, 2'b00, 6'h02, {32'h0, 32'h99}, {32'h0, 32'hAA}, 16'h0034, 1, 1);
    for (int n = 1; n < 3; n++) begin
      cyc();
      push("stall", 2'b01, 2'b01, 2'b00, 6'h02, {32'h0, 32'h99}, {32'h0, 32'hAA}, 16'h0034, 1, 1);
    end
    // C10: release stall
    cyc();
    ex_stall = 1'b0;
    push("stall3", 2'b01, 2'b01, 2'b00, 6'h02, {32'h0, 32'h99}, {32'h0, 32'hAA}, 16'h0034, 0, 1);
    // C11: pending captured; flush with stall and load-use all asserted
    cyc();
    clear_id();
    flush = 1'b1; ex_stall = 1'b1;
    set_slot(0, 1, 3'd6, 1, 3'd0, 0, 3'd4, 32'hD1, 32'hD2, 8'h9A, 1, 0);
    push("pending", 2'b11, 2'b11, 2'b10, 6'h33, {32'hC1, 32'hB1}, {32'hC2, 32'hB2}, 16'h7856, 0, 1);
    // C12: flushed; present bypass bundle
    cyc();
    flush = 1'b0; ex_stall = 1'b0;
    clear_id();
    set_slot(0, 1, 3'd2, 1, 3'd0, 0, 3'd1, 32'h00, 32'h10, 8'h01, 1, 0);
    wb_we = 2'b11; wb_addr = {3'd2, 3'd2}; wb_data = {32'hBB, 32'hAA};
    push("flush", 2'b00, 2'b00, 2'b00, 6'h00, 64'h0, 64'h0, 16'h0, 0, 0);
    // C13: bypass result; start a stall
    cyc();
    clear_id();
    ex_stall = 1'b1;
    set_slot(1, 1, 3'd0, 0, 3'd0, 0, 3'd7, 32'hE1, 32'hE2, 8'hEE, 1, 1);
    push("bypass", 2'b01, 2'b01, 2'b00, 6'h01, {32'h0, byp}, {32'h0, 32'h10}, 16'h0001, 1, 1);
    // C14: asynchronous reset in the middle of the stall
    cyc();
    reset = 1'b0; ex_stall = 1'b0;
    push("midrst", 2'b00, 2'b00, 2'b00, 6'h00, 64'h0, 64'h0, 16'h0, 0, 1);
    cyc();
    reset = 1'b1; clear_id();
    push("rst_rel", 2'b00, 2'b00, 2'b00, 6'h00, 64'h0, 64'h0, 16'h0, 0, 1);
    for (int n = 0; n < 4 && q.size() > 0; n++) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: actual=%0d required=0 pending expectations", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "timeout");
  end

endmodule
